// File: rtl/cim_seq_ctrl.sv
// Bit-serial compute-in-memory sequencer: runs one job over bit-planes 0..L while a
// weight loader fills the shadow bank, then swaps banks once the job FSM is idle.
module cim_seq_ctrl #(
    parameter int WEIGHT_BITS = 12,
    parameter int WDEPTH      = 144,
    parameter int ACC_LAT     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [3:0]             cfg_last_sel,
    input  logic                   cfg_signed,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [WEIGHT_BITS-1:0] w_data,
    output logic [3:0]             sel,
    output logic                   mac_on_pong_row,
    output logic                   write_to_pong_row,
    output logic                   start_acc,
    output logic                   signed_op,
    output logic                   we,
    output logic [7:0]             wa,
    output logic [WEIGHT_BITS-1:0] d_in,
    output logic                   busy,
    output logic                   out_valid,
    output logic                   swap_pulse,
    output logic [1:0]             fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_ROW   = 8'(WDEPTH - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(ACC_LAT - 1);

    state_t                 state, state_n;
    logic [3:0]             last_sel, last_sel_n;
    logic [3:0]             drain_cnt, drain_cnt_n;
    logic [7:0]             wr_ptr, wr_ptr_n;
    logic                   shadow_full, shadow_full_n;
    logic                   bank_valid, bank_valid_n;

    logic [3:0]             sel_n;
    logic                   start_acc_n, signed_op_n, we_n, mac_n, wtp_n;
    logic                   busy_n, out_valid_n, swap_n, start_ready_n, w_ready_n;
    logic [7:0]             wa_n;
    logic [WEIGHT_BITS-1:0] d_in_n;
    logic                   start_fire, w_fire;

    // Handshakes: a transfer happens on the rising edge where valid and ready are both 1.
    // Both ready outputs are flops computed from next-cycle state, so they never depend
    // combinationally on valid; valid may be held or dropped freely and nothing is queued.
    assign start_fire = start_valid && start_ready;
    assign w_fire     = w_valid && w_ready;
    assign fsm_state  = state;

    always_comb begin
        state_n       = state;
        last_sel_n    = last_sel;
        drain_cnt_n   = drain_cnt;
        wr_ptr_n      = wr_ptr;
        shadow_full_n = shadow_full;
        bank_valid_n  = bank_valid;
        sel_n         = sel;
        start_acc_n   = 1'b0;
        signed_op_n   = signed_op;
        we_n          = 1'b0;
        wa_n          = wa;
        d_in_n        = d_in;
        wtp_n         = write_to_pong_row;
        mac_n         = mac_on_pong_row;

        case (state)
            IDLE: begin
                if (start_fire) begin
                    state_n     = RUN;
                    last_sel_n  = cfg_last_sel;
                    signed_op_n = cfg_signed;
                    sel_n       = 4'd0;
                    start_acc_n = 1'b1;
                end
            end
            RUN: begin
                if (sel == last_sel) begin
                    state_n     = DRAIN;
                    drain_cnt_n = DRAIN_LAST;
                end else begin
                    sel_n = sel + 4'd1;
                end
            end
            DRAIN: begin
                if (drain_cnt == 4'd0) begin
                    state_n = DONE;
                end else begin
                    drain_cnt_n = drain_cnt - 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Loader writes into whichever bank the MAC side is not reading.
        if (w_fire) begin
            we_n   = 1'b1;
            wa_n   = wr_ptr;
            d_in_n = w_data;
            wtp_n  = ~mac_on_pong_row;
            if (wr_ptr == LAST_ROW) begin
                wr_ptr_n      = 8'd0;
                shadow_full_n = 1'b1;
            end else begin
                wr_ptr_n = wr_ptr + 8'd1;
            end
        end

        // swap_pulse is high exactly in the cycle the swap takes effect at its closing edge.
        if (swap_pulse) begin
            mac_n         = ~mac_on_pong_row;
            bank_valid_n  = 1'b1;
            shadow_full_n = 1'b0;
        end

        swap_n        = shadow_full_n && (state_n == IDLE) && !we_n;
        start_ready_n = (state_n == IDLE) && bank_valid_n && !swap_n;
        w_ready_n     = !shadow_full_n;
        busy_n        = (state_n != IDLE);
        out_valid_n   = (state_n == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            last_sel          <= 4'd0;
            drain_cnt         <= 4'd0;
            wr_ptr            <= 8'd0;
            shadow_full       <= 1'b0;
            bank_valid        <= 1'b0;
            sel               <= 4'd0;
            start_acc         <= 1'b0;
            signed_op         <= 1'b0;
            we                <= 1'b0;
            wa                <= 8'd0;
            d_in              <= '0;
            write_to_pong_row <= 1'b0;
            mac_on_pong_row   <= 1'b0;
            swap_pulse        <= 1'b0;
            start_ready       <= 1'b0;
            w_ready           <= 1'b0;
            busy              <= 1'b0;
            out_valid         <= 1'b0;
        end else begin
            state             <= state_n;
            last_sel          <= last_sel_n;
            drain_cnt         <= drain_cnt_n;
            wr_ptr            <= wr_ptr_n;
            shadow_full       <= shadow_full_n;
            bank_valid        <= bank_valid_n;
            sel               <= sel_n;
            start_acc         <= start_acc_n;
            signed_op         <= signed_op_n;
            we                <= we_n;
            wa                <= wa_n;
            d_in              <= d_in_n;
            write_to_pong_row <= wtp_n;
            mac_on_pong_row   <= mac_n;
            swap_pulse        <= swap_n;
            start_ready       <= start_ready_n;
            w_ready           <= w_ready_n;
            busy              <= busy_n;
            out_valid         <= out_valid_n;
        end
    end

endmodule

// File: tb/tb_cim_seq_ctrl.sv
// Bench for cim_seq_ctrl: job timing table, bank load/swap sequences and mid-job reset,
// with every weight write checked against an expected queue.
`timescale 1ns/1ps
module tb_cim_seq_ctrl;

    localparam int WB   = 12;
    localparam int WD   = 144;
    localparam int AL   = 2;
    localparam int SB_W = 8 + 1 + WB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [3:0]    cfg_last_sel = 4'd0;
    logic          cfg_signed = 1'b0;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [WB-1:0] w_data = '0;
    logic [3:0]    sel;
    logic          mac_on_pong_row, write_to_pong_row, start_acc, signed_op, we;
    logic [7:0]    wa;
    logic [WB-1:0] d_in;
    logic          busy, out_valid, swap_pulse;
    logic [1:0]    fsm_state;

    cim_seq_ctrl #(.WEIGHT_BITS(WB), .WDEPTH(WD), .ACC_LAT(AL)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .cfg_last_sel(cfg_last_sel), .cfg_signed(cfg_signed),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .sel(sel), .mac_on_pong_row(mac_on_pong_row), .write_to_pong_row(write_to_pong_row),
        .start_acc(start_acc), .signed_op(signed_op), .we(we), .wa(wa), .d_in(d_in),
        .busy(busy), .out_valid(out_valid), .swap_pulse(swap_pulse), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard: expected {wa, write_to_pong_row, d_in} per accepted weight
    logic [SB_W-1:0] exp_q[$];
    logic [SB_W-1:0] sb_exp;
    int m_ptr = 0;
    int m_banks = 0;

    typedef struct {
        logic [3:0] last_sel;
        logic       sgn;
        int         lat;
    } job_t;
    job_t jobs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("we_unexpected", {31'd0, we}, 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("write_port", {11'd0, wa, write_to_pong_row, d_in}, {11'd0, sb_exp});
            end
        end
        if (rst_n !== 1'b1) begin
            exp_q.delete();
            m_ptr   = 0;
            m_banks = 0;
        end else if (w_valid && w_ready) begin
            exp_q.push_back({8'(m_ptr), ~m_banks[0], w_data});
            m_ptr++;
            if (m_ptr == WD) begin
                m_ptr = 0;
                m_banks++;
            end
        end
    end

    // driver tasks
    task automatic load_n(input int n, output int cycles);
        int got;
        got    = 0;
        cycles = 0;
        while (got < n && cycles < 1000) begin
            w_valid = 1'b1;
            w_data  = 12'($urandom_range(0, 4095));
            if (w_ready) got++;
            tick();
            cycles++;
        end
        w_valid = 1'b0;
        chk("load_count", got, n);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_start_acc"}, start_acc, 0);
        chk({tag, "_signed_op"}, signed_op, 0);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_wa"}, wa, 0);
        chk({tag, "_d_in"}, d_in, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_swap_pulse"}, swap_pulse, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mac_pong"}, mac_on_pong_row, 0);
        chk({tag, "_wr_pong"}, write_to_pong_row, 0);
        chk({tag, "_start_ready"}, start_ready, 0);
        chk({tag, "_w_ready"}, w_ready, 0);
        chk({tag, "_state"}, fsm_state, 0);
    endtask

    task automatic run_job(input logic [3:0] l, input logic sgn, input int lat);
        int waited;
        waited = 0;
        while (!start_ready && waited < 400) begin
            tick();
            waited++;
        end
        chk("job_ready", start_ready, 1);
        start_valid  = 1'b1;
        cfg_last_sel = l;
        cfg_signed   = sgn;
        tick();
        start_valid  = 1'b0;
        cfg_last_sel = 4'($urandom_range(0, 15));
        cfg_signed   = ~sgn;
        for (int k = 1; k <= lat; k++) begin
            int es;
            int est;
            es  = (k - 1 <= int'(l)) ? k - 1 : int'(l);
            est = (k <= int'(l) + 1) ? 1 : ((k < lat) ? 2 : 3);
            chk("job_sel", sel, es);
            chk("job_state", fsm_state, est);
            chk("job_start_acc", start_acc, (k == 1));
            chk("job_busy", busy, 1);
            chk("job_out_valid", out_valid, (k == lat));
            chk("job_start_ready", start_ready, 0);
            chk("job_signed_op", signed_op, sgn);
            tick();
        end
        chk("job_busy_end", busy, 0);
        chk("job_out_valid_end", out_valid, 0);
        chk("job_signed_hold", signed_op, sgn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        int cyc;
        int n;
        int seen_ov, seen_sw, seen_sr;
        jobs[0] = '{4'd3,  1'b1, 7};
        jobs[1] = '{4'd0,  1'b0, 4};
        jobs[2] = '{4'd15, 1'b1, 19};
        jobs[3] = '{4'd7,  1'b0, 11};

        repeat (3) tick();
        chk_reset_outputs("rst0");
        rst_n = 1'b1;
        chk("w_ready_first", w_ready, 0);
        tick();
        chk("w_ready_after", w_ready, 1);

        // start requested before any bank exists
        start_valid  = 1'b1;
        cfg_last_sel = 4'd2;
        for (int i = 0; i < 8; i++) begin
            chk("nobank_start_ready", start_ready, 0);
            chk("nobank_busy", busy, 0);
            tick();
        end
        start_valid = 1'b0;

        // first full bank, back-to-back
        load_n(WD, cyc);
        chk("s1_b2b_cycles", cyc, WD);
        chk("s1_we_last", we, 1);
        chk("s1_wa_last", wa, WD - 1);
        chk("s1_w_ready_full", w_ready, 0);
        chk("s1_swap_early", swap_pulse, 0);
        chk("s1_mac_before", mac_on_pong_row, 0);
        tick();
        chk("s1_swap", swap_pulse, 1);
        chk("s1_we_off", we, 0);
        chk("s1_ready_in_swap", start_ready, 0);
        chk("s1_mac_in_swap", mac_on_pong_row, 0);
        tick();
        chk("s1_mac_after", mac_on_pong_row, 1);
        chk("s1_swap_once", swap_pulse, 0);
        chk("s1_start_ready", start_ready, 1);
        chk("s1_w_ready_again", w_ready, 1);

        for (int i = 0; i < 4; i++) run_job(jobs[i].last_sel, jobs[i].sgn, jobs[i].lat);

        // partial load never swaps
        load_n(WD - 4, cyc);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s4_partial_swap", swap_pulse, 0);
            chk("s4_partial_mac", mac_on_pong_row, 1);
            chk("s4_partial_ready", start_ready, 1);
        end

        // rest of bank arrives during a 16-plane job; swap waits for IDLE
        start_valid  = 1'b1;
        cfg_last_sel = 4'd15;
        cfg_signed   = 1'b0;
        tick();
        start_valid = 1'b0;
        n = 0;
        for (int k = 1; k <= 19; k++) begin
            if (n < 4) begin
                w_valid = 1'b1;
                w_data  = 12'($urandom_range(0, 4095));
                if (w_ready) n++;
            end else begin
                w_valid = 1'b0;
            end
            chk("s4_mac_hold", mac_on_pong_row, 1);
            chk("s4_no_swap_busy", swap_pulse, 0);
            chk("s4_busy", busy, 1);
            if (k >= 5) chk("s4_w_ready_full", w_ready, 0);
            if (k == 19) begin
                chk("s4_out_valid", out_valid, 1);
                start_valid  = 1'b1;
                cfg_last_sel = 4'd0;
                cfg_signed   = 1'b1;
            end
            tick();
        end
        w_valid = 1'b0;
        chk("s4_idle_busy", busy, 0);
        chk("s4_idle_swap", swap_pulse, 1);
        chk("s4_idle_ready", start_ready, 0);
        chk("s4_idle_mac", mac_on_pong_row, 1);
        tick();
        chk("s4_mac_swapped", mac_on_pong_row, 0);
        chk("s4_swap_once", swap_pulse, 0);
        chk("s4_ready_after", start_ready, 1);
        chk("s4_w_ready_after", w_ready, 1);
        tick();
        start_valid = 1'b0;
        chk("s4_pending_busy", busy, 1);
        chk("s4_pending_sel", sel, 0);
        chk("s4_pending_acc", start_acc, 1);
        chk("s4_pending_signed", signed_op, 1);
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("s4_job2_done", out_valid, 1);
        chk("s4_job2_lat", n, 3);
        tick();

        // reset mid-job with a partial load
        load_n(70, cyc);
        chk("s5_ready", start_ready, 1);
        start_valid  = 1'b1;
        cfg_last_sel = 4'd15;
        cfg_signed   = 1'b1;
        tick();
        start_valid = 1'b0;
        repeat (5) tick();
        chk("s5_sel5", sel, 5);
        chk("s5_signed", signed_op, 1);
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("s5rst");
        tick();
        rst_n = 1'b1;
        chk("s5_w_ready_first", w_ready, 0);
        tick();
        chk("s5_w_ready_after", w_ready, 1);
        seen_ov = 0;
        seen_sw = 0;
        seen_sr = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen_ov++;
            if (swap_pulse) seen_sw++;
            if (start_ready) seen_sr++;
            tick();
        end
        chk("s5_no_out_valid", seen_ov, 0);
        chk("s5_no_swap", seen_sw, 0);
        chk("s5_no_start_ready", seen_sr, 0);
        load_n(WD, cyc);
        run_job(4'd2, 1'b1, 6);

        tick();
        tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cim_seq_ctrl.md
CIM_SEQ_CTRL -- requirements
Module: cim_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WEIGHT_BITS, default 12, giving the weight word width.
REQ-002 The block SHALL have parameter WDEPTH, default 144, giving the rows per weight bank (legal range 1..256).
REQ-003 The block SHALL have parameter ACC_LAT, default 2, giving the cycles from the last MAC cycle to a valid accumulator nout (legal range 1..15).
REQ-004 The block SHALL have a single clock and synchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, synchronous, active-low.
REQ-005 The block SHALL have the following job-command ports:
- start_valid input 1, job request.
- start_ready output 1, job accept.
- cfg_last_sel input 4, last bit-plane index; the job runs sel 0..cfg_last_sel.
- cfg_signed input 1, signed job.
REQ-006 The block SHALL have the following weight-stream ports: w_valid input 1; w_ready output 1; w_data input WEIGHT_BITS.
REQ-007 The block SHALL have the following array-control outputs:
- sel output 4.
- mac_on_pong_row output 1.
- write_to_pong_row output 1.
- start_acc output 1.
- signed_op output 1.
- we output 1.
- wa output 8.
- d_in output WEIGHT_BITS.
REQ-008 The block SHALL have the following status outputs: busy output 1, a job is in progress; out_valid output 1, one-cycle pulse when nout is valid; swap_pulse output 1, one-cycle pulse on a bank swap.

Function
REQ-009 Job FSM states SHALL be IDLE, RUN, DRAIN and DONE, with all outputs registered.
REQ-010 start_ready SHALL be 1 only when all of the following hold: state is IDLE, bank_valid is 1, and no swap occurs in that cycle.
REQ-011 On a start handshake at cycle T, the block SHALL latch cfg_last_sel into L and cfg_signed into signed_op.
- It SHALL then enter RUN at T+1.
- signed_op SHALL hold its value until the next accepted start.
REQ-012 In RUN, sel SHALL be 0 at T+1 and increment by 1 per cycle up to L.
- After sel==L the FSM SHALL go to DRAIN.
- RUN lasts L+1 cycles; L=15 gives 16 cycles with no wrap.
REQ-013 start_acc SHALL be 1 exactly in the RUN cycle with sel==0 and 0 otherwise.
REQ-014 DRAIN SHALL last ACC_LAT cycles with sel held at L, followed by DONE for 1 cycle with out_valid=1, then IDLE.
- Total latency: out_valid at T+L+2+ACC_LAT.
REQ-015 busy SHALL be 1 in RUN, DRAIN and DONE.
REQ-016 start_valid outside the accept condition SHALL be ignored, with no queuing.
REQ-017 The weight loader SHALL accept w_data when w_valid&&w_ready.
- On the next cycle it SHALL drive we=1, wa=wr_ptr, d_in=w_data and write_to_pong_row=~mac_on_pong_row, all registered together.
- we SHALL be 0 otherwise.
REQ-018 wr_ptr SHALL reset to 0 and increment per accept.
- On the accept with wr_ptr==WDEPTH-1 it SHALL wrap to 0 and set shadow_full=1.
- While shadow_full=1, w_ready SHALL be 0.
REQ-019 A swap SHALL occur in any cycle where all of the following hold: shadow_full=1, state is IDLE, and we=0, so the final write retires first.
- A swap SHALL toggle mac_on_pong_row, set bank_valid=1, clear shadow_full and pulse swap_pulse.
REQ-020 Swap SHALL have priority over start.
- start_valid present in a swap cycle SHALL be accepted at the earliest the following cycle.
REQ-021 mac_on_pong_row SHALL never change while busy=1; a completed shadow bank waits in shadow_full until IDLE.
REQ-022 Weight loading SHALL proceed concurrently with RUN/DRAIN/DONE into the non-active bank.
REQ-023 A partial load (fewer than WDEPTH accepts) SHALL never swap.

Reset
REQ-024 When rst_n=0 at a clk edge, all of the following SHALL result:
- State IDLE.
- sel, start_acc, signed_op, we, wa, d_in, out_valid, swap_pulse, busy, mac_on_pong_row, write_to_pong_row all 0.
- wr_ptr=0, shadow_full=0, bank_valid=0.
REQ-025 During reset and the first cycle of reset, start_ready and w_ready SHALL be 0; w_ready SHALL be 1 in the first cycle after rst_n=1.
REQ-026 Reset asserted mid-job or mid-load SHALL abandon all progress with no out_valid and no swap, and reload SHALL be required before start_ready=1.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- WDEPTH=144, 144 back-to-back w_valid from reset -> we for 144 cycles with wa 0..143 and write_to_pong_row=1; swap_pulse one cycle after the last we; mac_on_pong_row=1; start_ready=1 next cycle.
- start at T with cfg_last_sel=3, cfg_signed=1, ACC_LAT=2 -> sel 0,1,2,3 at T+1..T+4; start_acc only at T+1; signed_op=1; out_valid only at T+7; start_ready 0 during T+1..T+7.
- start_valid held high before any bank loaded -> start_ready stays 0 and no RUN.
- Second full bank loaded during a cfg_last_sel=15 job -> w_ready=0 after 144 accepts; mac_on_pong_row unchanged until DONE; swap in the first IDLE cycle; the start request pending that cycle is accepted one cycle later.
- rst_n=0 at sel==5 of a job, with 70 weights loaded -> all outputs 0; no out_valid; w_ready=1 after release; wa restarts at 0.
